// File: rtl/riscv_pkg.sv
// ============================================================================
// Module : riscv_pkg
// Brief  : Shared encodings for the RV32I multi-cycle control unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

  localparam logic [6:0] c_op_rtype  = 7'b0110011;
  localparam logic [6:0] c_op_imm    = 7'b0010011;
  localparam logic [6:0] c_op_lui    = 7'b0110111;
  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_jal    = 7'b1101111;

  localparam logic [3:0] c_alu_and = 4'd0;
  localparam logic [3:0] c_alu_or  = 4'd1;
  localparam logic [3:0] c_alu_add = 4'd2;
  localparam logic [3:0] c_alu_sub = 4'd6;
  localparam logic [3:0] c_alu_slt = 4'd7;
  localparam logic [3:0] c_alu_nor = 4'd12;

  localparam logic [1:0] c_src_a_pc    = 2'd0;
  localparam logic [1:0] c_src_a_oldpc = 2'd1;
  localparam logic [1:0] c_src_a_rs1   = 2'd2;
  localparam logic [1:0] c_src_a_zero  = 2'd3;

  localparam logic [1:0] c_src_b_rs2   = 2'd0;
  localparam logic [1:0] c_src_b_const4 = 2'd1;
  localparam logic [1:0] c_src_b_imm   = 2'd2;

  localparam logic [1:0] c_wb_aluout = 2'd0;
  localparam logic [1:0] c_wb_mdr    = 2'd1;
  localparam logic [1:0] c_wb_pc     = 2'd2;

  typedef enum logic [3:0] {
    RST_IDLE = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    EXEC_R   = 4'd3,
    EXEC_I   = 4'd4,
    MEM_ADDR = 4'd5,
    MEM_RD   = 4'd6,
    MEM_WR   = 4'd7,
    WB_ALU   = 4'd8,
    WB_MEM   = 4'd9,
    BRANCH   = 4'd10,
    JAL      = 4'd11,
    TRAP     = 4'd12
  } state_e;

endpackage

`default_nettype wire

// File: rtl/riscv_alu_dec.sv
// ============================================================================
// Module : riscv_alu_dec
// Brief  : Combinational funct3/funct7 to ALU control decode with illegal flag.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module riscv_alu_dec
  import riscv_pkg::*;
(
  input  logic       is_rtype,
  input  logic       is_lui,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [3:0] alu_ctl,
  output logic       illegal
);

  always_comb begin
    alu_ctl = c_alu_add;
    illegal = 1'b0;
    // LUI carries immediate bits in the funct3 field, so it is decoded first
    if (is_lui) begin
      alu_ctl = c_alu_add;
    end else begin
      case (funct3)
        3'b000:  alu_ctl = (is_rtype && funct7_5) ? c_alu_sub : c_alu_add;
        3'b111:  alu_ctl = c_alu_and;
        3'b110:  alu_ctl = c_alu_or;
        3'b010:  alu_ctl = c_alu_slt;
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/riscv_multicycle_ctrl.sv
// ============================================================================
// Module : riscv_multicycle_ctrl
// Brief  : Multi-cycle RV32I control FSM with sticky trap and instret counter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module riscv_multicycle_ctrl
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        funct7_5,
  input  logic        alu_zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ir_we,
  output logic        pc_we,
  output logic        reg_we,
  output logic        mdr_we,
  output logic [3:0]  alu_ctl,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic        pc_src,
  output logic [1:0]  wb_sel,
  output logic        trap,
  output logic [31:0] instret
);

  state_e      r_state;
  state_e      w_state_nxt;
  logic [31:0] r_instret;
  logic        w_retire;
  logic [3:0]  w_dec_alu_ctl;
  logic        w_dec_illegal;
  logic        w_is_lui;

  assign w_is_lui = (opcode == c_op_lui);
  assign instret  = r_instret;

  riscv_alu_dec u_alu_dec (
    .is_rtype (r_state == EXEC_R),
    .is_lui   (w_is_lui),
    .funct3   (funct3),
    .funct7_5 (funct7_5),
    .alu_ctl  (w_dec_alu_ctl),
    .illegal  (w_dec_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= RST_IDLE;
      r_instret <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_retire) r_instret <= r_instret + 32'd1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_retire    = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    reg_we      = 1'b0;
    mdr_we      = 1'b0;
    alu_ctl     = c_alu_add;
    alu_src_a   = c_src_a_pc;
    alu_src_b   = c_src_b_rs2;
    pc_src      = 1'b0;
    wb_sel      = c_wb_aluout;
    trap        = 1'b0;

    case (r_state)
      RST_IDLE: w_state_nxt = FETCH;
      FETCH: begin
        mem_req   = 1'b1;
        alu_src_a = c_src_a_pc;
        alu_src_b = c_src_b_const4;
        ir_we     = mem_ready;
        pc_we     = mem_ready;
        if (mem_ready) w_state_nxt = DECODE;
      end
      DECODE: begin
        // ALUOut captures OLDPC+imm here as the branch/JAL target
        alu_src_a = c_src_a_oldpc;
        alu_src_b = c_src_b_imm;
        case (opcode)
          c_op_rtype:           w_state_nxt = EXEC_R;
          c_op_imm, c_op_lui:   w_state_nxt = EXEC_I;
          c_op_load, c_op_store: w_state_nxt = MEM_ADDR;
          c_op_branch:          w_state_nxt = (funct3[2:1] == 2'b00) ? BRANCH : TRAP;
          c_op_jal:             w_state_nxt = JAL;
          default:              w_state_nxt = TRAP;
        endcase
      end
      EXEC_R: begin
        alu_src_a   = c_src_a_rs1;
        alu_src_b   = c_src_b_rs2;
        alu_ctl     = w_dec_alu_ctl;
        w_state_nxt = w_dec_illegal ? TRAP : WB_ALU;
      end
      EXEC_I: begin
        alu_src_a   = w_is_lui ? c_src_a_zero : c_src_a_rs1;
        alu_src_b   = c_src_b_imm;
        alu_ctl     = w_dec_alu_ctl;
        w_state_nxt = w_dec_illegal ? TRAP : WB_ALU;
      end
      MEM_ADDR: begin
        alu_src_a   = c_src_a_rs1;
        alu_src_b   = c_src_b_imm;
        w_state_nxt = (opcode == c_op_load) ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        mem_req = 1'b1;
        mdr_we  = mem_ready;
        if (mem_ready) w_state_nxt = WB_MEM;
      end
      MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ready) begin
          w_retire    = 1'b1;
          w_state_nxt = FETCH;
        end
      end
      WB_ALU, WB_MEM: begin
        reg_we      = 1'b1;
        wb_sel      = (r_state == WB_MEM) ? c_wb_mdr : c_wb_aluout;
        w_retire    = 1'b1;
        w_state_nxt = FETCH;
      end
      BRANCH: begin
        alu_src_a   = c_src_a_rs1;
        alu_src_b   = c_src_b_rs2;
        alu_ctl     = c_alu_sub;
        pc_src      = 1'b1;
        pc_we       = alu_zero ^ funct3[0];
        w_retire    = 1'b1;
        w_state_nxt = FETCH;
      end
      JAL: begin
        pc_we       = 1'b1;
        pc_src      = 1'b1;
        reg_we      = 1'b1;
        wb_sel      = c_wb_pc;
        w_retire    = 1'b1;
        w_state_nxt = FETCH;
      end
      TRAP: trap = 1'b1;
      default: w_state_nxt = RST_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_riscv_multicycle_ctrl.sv
// ============================================================================
// Module : tb_riscv_multicycle_ctrl
// Brief  : Directed self-checking bench for the multi-cycle control unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_riscv_multicycle_ctrl;
  import riscv_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic        alu_zero;
  logic        mem_ready;
  logic        mem_req, mem_we, ir_we, pc_we, reg_we, mdr_we, pc_src, trap;
  logic [3:0]  alu_ctl;
  logic [1:0]  alu_src_a, alu_src_b, wb_sel;
  logic [31:0] instret;

  int n_vec = 0;
  int n_err = 0;

  riscv_multicycle_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .opcode    (opcode),
    .funct3    (funct3),
    .funct7_5  (funct7_5),
    .alu_zero  (alu_zero),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .ir_we     (ir_we),
    .pc_we     (pc_we),
    .reg_we    (reg_we),
    .mdr_we    (mdr_we),
    .alu_ctl   (alu_ctl),
    .alu_src_a (alu_src_a),
    .alu_src_b (alu_src_b),
    .pc_src    (pc_src),
    .wb_sel    (wb_sel),
    .trap      (trap),
    .instret   (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; opcode = '0; funct3 = '0; funct7_5 = 1'b0;
    alu_zero = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state",   32'(dut.r_state), 32'(RST_IDLE));
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_alu_ctl", 32'(alu_ctl), 2);
    chk("rst_instret", instret, 0);
    chk("rst_trap",    32'(trap), 0);
    rst_n = 1'b1; #1;
    chk("rel_state",   32'(dut.r_state), 32'(RST_IDLE));
    chk("rel_mem_req", 32'(mem_req), 0);
    tick();
    chk("first_req",   32'(mem_req), 1);

    // ADD
    opcode = c_op_rtype; funct3 = 3'b000; funct7_5 = 1'b0; #1;
    chk("add_f_ir_we", 32'(ir_we), 1);
    chk("add_f_pc_we", 32'(pc_we), 1);
    chk("add_f_src_b", 32'(alu_src_b), 1);
    tick();
    chk("add_d_src_a", 32'(alu_src_a), 1);
    chk("add_d_src_b", 32'(alu_src_b), 2);
    tick();
    chk("add_e_alu",   32'(alu_ctl), 2);
    chk("add_e_src_a", 32'(alu_src_a), 2);
    chk("add_e_src_b", 32'(alu_src_b), 0);
    tick();
    chk("add_wb_reg_we", 32'(reg_we), 1);
    chk("add_wb_sel",    32'(wb_sel), 0);
    tick();
    chk("add_instret", instret, 1);

    // SUB
    funct7_5 = 1'b1;
    tick(); tick();
    chk("sub_e_alu", 32'(alu_ctl), 6);
    tick();
    chk("sub_wb_reg_we", 32'(reg_we), 1);
    tick();
    chk("sub_instret", instret, 2);

    // LW with 3 fetch waits and 2 read waits
    opcode = c_op_load; funct3 = 3'b010; funct7_5 = 1'b0; mem_ready = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      chk("lw_fw_req",   32'(mem_req), 1);
      chk("lw_fw_ir_we", 32'(ir_we), 0);
      tick();
    end
    mem_ready = 1'b1; #1;
    chk("lw_f_ir_we", 32'(ir_we), 1);
    tick();
    chk("lw_d_ir_we", 32'(ir_we), 0);
    tick();
    chk("lw_ma_src_a", 32'(alu_src_a), 2);
    chk("lw_ma_src_b", 32'(alu_src_b), 2);
    tick();
    mem_ready = 1'b0; #1;
    for (int i = 0; i < 2; i++) begin
      chk("lw_rw_mdr_we", 32'(mdr_we), 0);
      chk("lw_rw_req",    32'(mem_req), 1);
      chk("lw_rw_we",     32'(mem_we), 0);
      tick();
    end
    mem_ready = 1'b1; #1;
    chk("lw_rd_mdr_we", 32'(mdr_we), 1);
    tick();
    chk("lw_wb_reg_we", 32'(reg_we), 1);
    chk("lw_wb_sel",    32'(wb_sel), 1);
    chk("lw_wb_mdr_we", 32'(mdr_we), 0);
    tick();
    chk("lw_instret", instret, 3);
    chk("lw_state",   32'(dut.r_state), 32'(FETCH));

    // SW
    opcode = c_op_store;
    tick(); tick(); tick();
    chk("sw_req", 32'(mem_req), 1);
    chk("sw_we",  32'(mem_we), 1);
    tick();
    chk("sw_instret", instret, 4);

    // BEQ taken
    opcode = c_op_branch; funct3 = 3'b000; alu_zero = 1'b1;
    tick(); tick();
    chk("beq_pc_we",  32'(pc_we), 1);
    chk("beq_pc_src", 32'(pc_src), 1);
    chk("beq_alu",    32'(alu_ctl), 6);
    tick();
    chk("beq_instret", instret, 5);

    // BNE with zero and nonzero
    funct3 = 3'b001;
    tick(); tick();
    chk("bne_z_pc_we", 32'(pc_we), 0);
    alu_zero = 1'b0; #1;
    chk("bne_nz_pc_we", 32'(pc_we), 1);
    tick();
    chk("bne_instret", instret, 6);

    // JAL across the instret wrap point
    force dut.r_instret = 32'hFFFF_FFFF;
    #1;
    release dut.r_instret;
    opcode = c_op_jal;
    tick(); tick();
    chk("jal_pc_we",  32'(pc_we), 1);
    chk("jal_pc_src", 32'(pc_src), 1);
    chk("jal_reg_we", 32'(reg_we), 1);
    chk("jal_wb_sel", 32'(wb_sel), 2);
    tick();
    chk("jal_wrap_instret", instret, 0);

    // LUI ignores funct3 and sources ZERO
    opcode = c_op_lui; funct3 = 3'b001;
    tick(); tick();
    chk("lui_src_a", 32'(alu_src_a), 3);
    chk("lui_alu",   32'(alu_ctl), 2);
    tick(); tick();
    chk("lui_instret", instret, 1);

    // ORI
    opcode = c_op_imm; funct3 = 3'b110;
    tick(); tick();
    chk("ori_alu",   32'(alu_ctl), 1);
    chk("ori_src_a", 32'(alu_src_a), 2);
    tick(); tick();
    chk("ori_instret", instret, 2);

    // Reset in the middle of a stalled MEM_RD
    opcode = c_op_load; funct3 = 3'b010;
    tick(); tick(); tick();
    mem_ready = 1'b0; #1;
    chk("mrd_state", 32'(dut.r_state), 32'(MEM_RD));
    rst_n = 1'b0; #1;
    chk("mrd_rst_state",   32'(dut.r_state), 32'(RST_IDLE));
    chk("mrd_rst_req",     32'(mem_req), 0);
    chk("mrd_rst_instret", instret, 0);
    mem_ready = 1'b1; rst_n = 1'b1;
    tick();

    // Illegal opcode
    opcode = 7'b0001111;
    tick(); tick();
    chk("ill_trap", 32'(trap), 1);
    chk("ill_req",  32'(mem_req), 0);
    repeat (3) tick();
    chk("ill_trap_hold", 32'(trap), 1);
    chk("ill_req_hold",  32'(mem_req), 0);
    chk("ill_instret",   instret, 0);

    rst_n = 1'b0; #1;
    chk("ill_rst_trap", 32'(trap), 0);
    rst_n = 1'b1;
    tick();

    // ADD, then R-type funct3 001 traps
    opcode = c_op_rtype; funct3 = 3'b000; funct7_5 = 1'b0;
    repeat (4) tick();
    chk("add2_instret", instret, 1);
    funct3 = 3'b001;
    tick(); tick();
    chk("rill_exec_trap", 32'(trap), 0);
    tick();
    chk("rill_trap", 32'(trap), 1);
    repeat (4) tick();
    chk("rill_trap_hold", 32'(trap), 1);
    chk("rill_instret",   instret, 1);
    chk("rill_req",       32'(mem_req), 0);
    chk("rill_reg_we",    32'(reg_we), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/riscv_multicycle_ctrl.md
# riscv_multicycle_ctrl

Multi-cycle control unit for the RV32I core: sequences fetch, decode, execute, memory and write-back over a single shared memory port, and is the block that drives the 4-bit ALU control code and consumes the ALU zero flag. It sits between the instruction register fields and the datapath muxes and write-enables. Unsupported encodings go to a sticky trap state. A retired-instruction counter is included.

## Interface
- No parameters; all encodings come from the shared package.
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  7  IR[6:0].
- funct3  in  3  IR[14:12].
- funct7_5  in  1  IR[30].
- alu_zero  in  1  ALU result == 0, valid in the current cycle.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request, held until mem_ready.
- mem_we  out  1  write request; valid with mem_req.
- ir_we, pc_we, reg_we, mdr_we  out  1 each  datapath register enables.
- alu_ctl  out  4  ALU control: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT, 12 NOR.
- alu_src_a  out  2  0 PC, 1 OLDPC, 2 RS1, 3 ZERO.
- alu_src_b  out  2  0 RS2, 1 CONST4, 2 IMM.
- pc_src  out  1  0 live ALU result, 1 ALUOut register.
- wb_sel  out  2  0 ALUOut, 1 MDR, 2 PC (link).
- trap  out  1  sticky illegal-instruction flag.
- instret  out  32  retired-instruction count.

## Operation
- States: RST_IDLE, FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, JAL, TRAP.
- RST_IDLE:
  - All outputs are 0 and alu_ctl = 2.
  - Next state is always FETCH.
- FETCH:
  - mem_req = 1, alu_src_a = PC, alu_src_b = CONST4, alu_ctl = ADD, pc_src = 0.
  - ir_we and pc_we pulse only in the cycle mem_ready = 1; that same cycle moves to DECODE.
- DECODE: alu_src_a = OLDPC, alu_src_b = IMM, ADD; this precomputes the branch/JAL target into ALUOut. Dispatch by opcode:
  - 0110011 → EXEC_R.
  - 0010011 or 0110111 (LUI) → EXEC_I.
  - 0000011 or 0100011 → MEM_ADDR.
  - 1100011 with funct3 000/001 → BRANCH.
  - 1101111 → JAL.
  - Anything else → TRAP.
- EXEC_R:
  - A = RS1, B = RS2.
  - alu_ctl by funct3/funct7_5: 000/0 ADD, 000/1 SUB, 111 AND, 110 OR, 010 SLT; anything else → TRAP.
  - Next state WB_ALU.
- EXEC_I:
  - B = IMM. A = ZERO for LUI with ADD, otherwise A = RS1.
  - funct3 000 ADD, 111 AND, 110 OR, 010 SLT; anything else → TRAP.
  - Next state WB_ALU.
- MEM_ADDR: A = RS1, B = IMM, ADD. Goes to MEM_RD for a load, MEM_WR for a store.
- MEM_RD: mem_req = 1, mdr_we on mem_ready, then WB_MEM.
- MEM_WR: mem_req = mem_we = 1; on mem_ready, retire and go to FETCH.
- WB_ALU / WB_MEM: reg_we = 1 with wb_sel 0 / 1; retire, then FETCH.
- BRANCH:
  - A = RS1, B = RS2, SUB, pc_src = 1.
  - pc_we = alu_zero XOR funct3[0]: BEQ takes the branch on zero, BNE on nonzero.
  - Retire, then FETCH.
- JAL: pc_we = 1, pc_src = 1, reg_we = 1, wb_sel = PC (already old+4). Retire, then FETCH.
- TRAP:
  - trap = 1 and all enables are 0.
  - Held until reset; instret frozen; a trapped instruction does not retire.
- Retire: instret increments by 1, wrapping at 2^32; 0xFFFFFFFF → 0.
- Idle outputs: enables are 0 in any state not listed above; alu_ctl defaults to ADD.

## Timing
- Moore outputs decode from state. Exceptions:
  - ir_we, pc_we and mdr_we are additionally gated by mem_ready.
  - The BRANCH pc_we is gated by alu_zero.
- Latency with zero-wait memory (mem_ready high on first request cycle):
  - R, I, LUI: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch, JAL: 3 cycles.
- Each memory wait cycle adds one cycle; mem_req and mem_we are stable while waiting.
- Reset:
  - rst_n low forces RST_IDLE immediately, mid-memory-request included, with trap = 0 and instret = 0.
  - The first mem_req appears in the second cycle after release.
- Ordering: instret updates on the same edge the state returns to FETCH.

## Structure
- riscv_pkg holds:
  - Opcode constants and ALU_Ctl codes (0, 1, 2, 6, 7, 12).
  - alu_src_a, alu_src_b and wb_sel encodings.
  - The state enum.
- Sub-module riscv_alu_dec: combinational decode of (is_rtype, is_lui, funct3, funct7_5) to alu_ctl plus an illegal flag. It is instantiated once, in the EXEC states.

## Test plan
- Reset:
  - Hold rst_n low, release → RST_IDLE for 1 cycle, then mem_req = 1.
  - Assert rst_n mid-MEM_RD → state RST_IDLE, mem_req = 0, instret = 0.
- ADD then SUB (opcode 0110011, funct3 000, funct7_5 0/1), mem_ready always high:
  - EXEC_R alu_ctl = 2, then 6; reg_we in cycle 4 of each.
  - instret = 2 after 8 cycles.
- LW with mem_ready low for 3 cycles in FETCH and 2 cycles in MEM_RD:
  - Completes in 10 cycles; ir_we and mdr_we are single-cycle pulses coinciding with mem_ready.
- BEQ with alu_zero = 1 → pc_we = 1, pc_src = 1 in BRANCH. BNE with alu_zero = 1 → pc_we = 0. Both retire after 3 cycles.
- Illegal instruction (opcode 0001111, or R-type funct3 001) → trap = 1 and stays set; mem_req = 0 thereafter; instret unchanged.
- instret preloaded via force to 0xFFFFFFFF, then retire a JAL → instret = 0; JAL asserts reg_we with wb_sel = 2.
